// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master drives requests and operands; the slave returns status and results.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH cycles per division.
// A zero divisor never enters RUN and reports all-ones / dividend one cycle later.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvsr;
    logic             dz_pending;
    logic             done_r;
    logic             dz_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quo;

    // The extra trial bit acts as the borrow, so divisors with MSB set cannot overflow.
    always_comb begin
        shifted  = {rem_r, quo_r[WIDTH-1]};
        trial    = shifted - {1'b0, dvsr};
        next_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        next_quo = {quo_r[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvsr        <= '0;
            dz_pending  <= 1'b0;
            done_r      <= 1'b0;
            dz_r        <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // quo_r holds the dividend while a divide-by-zero result is pending.
                    if (dz_pending) begin
                        dz_pending  <= 1'b0;
                        quotient_r  <= '1;
                        remainder_r <= quo_r;
                        dz_r        <= 1'b1;
                        done_r      <= 1'b1;
                    end else if (bus.start) begin
                        dz_r  <= 1'b0;
                        quo_r <= bus.dividend;
                        rem_r <= '0;
                        dvsr  <= bus.divisor;
                        if (bus.divisor == '0) begin
                            dz_pending <= 1'b1;
                        end else begin
                            cnt   <= CW'(WIDTH);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_r <= next_rem;
                    quo_r <= next_quo;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient_r  <= next_quo;
                        remainder_r <= next_rem;
                        done_r      <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state == RUN) || dz_pending;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dz_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: an arithmetic reference model is compared with the divider every
// cycle, alongside directed scenarios with hand-computed results and random traffic.
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a pending job counts down, then publishes results computed with / and %.
    int         mLeft = 0;
    logic       mDone = 1'b0;
    logic [W-1:0] mQ = '0, mR = '0, pQ = '0, pR = '0;
    logic       mDz = 1'b0, pDz = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mLeft = 0;
            mDone = 1'b0;
            mQ    = '0;
            mR    = '0;
            mDz   = 1'b0;
        end else begin
            mDone = 1'b0;
            if (mLeft > 0) begin
                mLeft--;
                if (mLeft == 0) begin
                    mQ    = pQ;
                    mR    = pR;
                    mDz   = pDz;
                    mDone = 1'b1;
                end
            end else if (bus.start) begin
                mDz = 1'b0;
                if (bus.divisor == '0) begin
                    pQ    = '1;
                    pR    = bus.dividend;
                    pDz   = 1'b1;
                    mLeft = 1;
                end else begin
                    pQ    = bus.dividend / bus.divisor;
                    pR    = bus.dividend % bus.divisor;
                    pDz   = 1'b0;
                    mLeft = W;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model.busy",      32'(bus.busy),        32'(mLeft > 0));
        checkOutput("model.done",      32'(bus.done),        32'(mDone));
        checkOutput("model.quotient",  32'(bus.quotient),    32'(mQ));
        checkOutput("model.remainder", 32'(bus.remainder),   32'(mR));
        checkOutput("model.dbz",       32'(bus.div_by_zero), 32'(mDz));
    end

    // Call at a falling edge: start is seen by the next rising edge, then dropped.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int expCycles);
        int n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, ".latency"}, 32'(n), 32'(expCycles));
    endtask

    task automatic checkResult(input string name, input logic [W-1:0] q, input logic [W-1:0] r,
                               input logic dz);
        checkOutput({name, ".done"}, 32'(bus.done), 32'd1);
        checkOutput({name, ".busy"}, 32'(bus.busy), 32'd0);
        checkOutput({name, ".q"},    32'(bus.quotient), 32'(q));
        checkOutput({name, ".r"},    32'(bus.remainder), 32'(r));
        checkOutput({name, ".dbz"},  32'(bus.div_by_zero), 32'(dz));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset.busy", 32'(bus.busy), 32'd0);
        checkOutput("reset.done", 32'(bus.done), 32'd0);
        checkOutput("reset.q",    32'(bus.quotient), 32'd0);
        checkOutput("reset.r",    32'(bus.remainder), 32'd0);
        checkOutput("reset.dbz",  32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(8'd100, 8'd7);   waitDone("d100_7", W);   checkResult("d100_7", 8'd14, 8'd2, 1'b0);
        applyStimulus(8'd255, 8'd1);   waitDone("d255_1", W);   checkResult("d255_1", 8'd255, 8'd0, 1'b0);
        applyStimulus(8'd255, 8'd255); waitDone("d255_255", W); checkResult("d255_255", 8'd1, 8'd0, 1'b0);
        applyStimulus(8'd200, 8'd129); waitDone("d200_129", W); checkResult("d200_129", 8'd1, 8'd71, 1'b0);
        applyStimulus(8'd5, 8'd9);     waitDone("d5_9", W);     checkResult("d5_9", 8'd0, 8'd5, 1'b0);
        applyStimulus(8'h37, 8'd0);    waitDone("dz", 1);       checkResult("dz", 8'hFF, 8'h37, 1'b1);
        applyStimulus(8'd10, 8'd3);    waitDone("d10_3", W);    checkResult("d10_3", 8'd3, 8'd1, 1'b0);

        // A start mid-run is ignored; one on the done cycle is taken immediately.
        @(negedge clk);
        applyStimulus(8'd100, 8'd7);
        repeat (2) @(negedge clk);
        applyStimulus(8'd9, 8'd3);
        waitDone("ignored", W - 3);
        checkResult("ignored", 8'd14, 8'd2, 1'b0);
        applyStimulus(8'd9, 8'd3);
        waitDone("b2b", W);
        checkResult("b2b", 8'd3, 8'd0, 1'b0);

        // Reset mid-run aborts without a done pulse.
        @(negedge clk);
        applyStimulus(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("abort.busy", 32'(bus.busy), 32'd0);
        checkOutput("abort.q",    32'(bus.quotient), 32'd0);
        checkOutput("abort.r",    32'(bus.remainder), 32'd0);
        applyStimulus(8'd50, 8'd6);
        waitDone("d50_6", W);
        checkResult("d50_6", 8'd8, 8'd2, 1'b0);

        // Random traffic, including zero, tiny and MSB-set divisors and rare resets.
        for (int i = 0; i < 1500; i++) begin
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.dividend = W'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0:       bus.divisor = '0;
                1:       bus.divisor = W'($urandom_range(1, 3));
                2:       bus.divisor = W'($urandom_range(128, 255));
                default: bus.divisor = W'($urandom_range(0, 255));
            endcase
            rst_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        rst_n     = 1'b1;
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
